// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, mstatus
// layout, writable masks and standard trap cause codes.
package csr_pkg;

   // CSR addresses (instruction bits [31:20])
   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   // mstatus field positions
   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   // Writable bits of the mie register (MSIE, MTIE, MEIE)
   localparam logic [31:0] MIE_WMASK = 32'h0000_0888;

   // Standard mcause codes
   localparam logic [31:0] MCAUSE_INSN_MISALIGNED = 32'd0;
   localparam logic [31:0] MCAUSE_ILLEGAL_INSN    = 32'd2;
   localparam logic [31:0] MCAUSE_BREAKPOINT      = 32'd3;
   localparam logic [31:0] MCAUSE_LOAD_MISALIGNED = 32'd4;
   localparam logic [31:0] MCAUSE_STORE_MISALIGN  = 32'd6;
   localparam logic [31:0] MCAUSE_ECALL_M         = 32'd11;
   localparam logic [31:0] MCAUSE_M_SW_INT        = 32'h8000_0003;
   localparam logic [31:0] MCAUSE_M_TIMER_INT     = 32'h8000_0007;
   localparam logic [31:0] MCAUSE_M_EXT_INT       = 32'h8000_000B;

   // Assemble the architectural mstatus view; MPP is fixed at machine mode
   function automatic logic [31:0] mstatus_pack(input logic mie, input logic mpie);
      logic [31:0] v;
      v = 32'h0;
      v[MSTATUS_MIE]                   = mie;
      v[MSTATUS_MPIE]                  = mpie;
      v[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      return v;
   endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit counter with an increment enable and independent writes of each
// 32-bit half. A written half takes the write data exactly; carries that
// would cross into or out of a written half are discarded.
module csr_counter64
   import csr_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   input  logic        we_lo,
   input  logic        we_hi,
   input  logic [31:0] wdata,
   output logic [63:0] value
);

   logic [63:0] cnt_q, cnt_d;
   logic [31:0] lo_inc;

   // Next count: plain increment unless one half is being written
   always_comb begin
      lo_inc = cnt_q[31:0] + {31'b0, inc};
      cnt_d  = cnt_q + {63'b0, inc};
      if (we_lo) begin
         cnt_d = {cnt_q[63:32], wdata};
      end else if (we_hi) begin
         cnt_d = {wdata, lo_inc};
      end
   end

   // Counter register
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= 64'h0;
      else        cnt_q <= cnt_d;
   end

   assign value = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR storage: combinational read, write commit on the next
// edge, cycle/instret counters, trap entry and mret updates.
module csr_file
   import csr_pkg::*;
#(
   parameter logic [31:0] HART_ID     = 32'd0,
   parameter logic [31:0] MISA_VAL    = 32'h4000_0100,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] csr_addr,
   output logic [31:0] csr_rdata,
   input  logic        csr_we,
   input  logic [31:0] csr_wdata,
   output logic        illegal_csr,
   input  logic        instr_retire,
   input  logic        trap_valid,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_tval,
   input  logic        mret,
   output logic [31:0] mtvec_out,
   output logic [31:0] mepc_out,
   output logic        mie_global
);

   logic        st_mie_q, st_mie_d;
   logic        st_mpie_q, st_mpie_d;
   logic [31:0] mie_reg_q, mie_reg_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic [31:0] mtval_q, mtval_d;
   logic [63:0] mcycle_val, minstret_val;
   logic        implemented, read_only, wr_ok;

   // Read mux and address decode
   always_comb begin
      csr_rdata   = 32'h0;
      implemented = 1'b1;
      unique case (csr_addr)
         CSR_MSTATUS:                csr_rdata = mstatus_pack(st_mie_q, st_mpie_q);
         CSR_MISA:                   csr_rdata = MISA_VAL;
         CSR_MIE:                    csr_rdata = mie_reg_q;
         CSR_MTVEC:                  csr_rdata = mtvec_q;
         CSR_MSCRATCH:               csr_rdata = mscratch_q;
         CSR_MEPC:                   csr_rdata = mepc_q;
         CSR_MCAUSE:                 csr_rdata = mcause_q;
         CSR_MTVAL:                  csr_rdata = mtval_q;
         CSR_MCYCLE,   CSR_CYCLE:    csr_rdata = mcycle_val[31:0];
         CSR_MCYCLEH,  CSR_CYCLEH:   csr_rdata = mcycle_val[63:32];
         CSR_MINSTRET, CSR_INSTRET:  csr_rdata = minstret_val[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = minstret_val[63:32];
         CSR_MHARTID:                csr_rdata = HART_ID;
         default:                    implemented = 1'b0;
      endcase
   end

   assign read_only   = (csr_addr[11:10] == 2'b11);
   assign wr_ok       = csr_we && implemented && !read_only;
   assign illegal_csr = !implemented || (csr_we && read_only);

   // Next state: trap beats mret beats software write on shared fields
   always_comb begin
      st_mie_d   = st_mie_q;
      st_mpie_d  = st_mpie_q;
      mie_reg_d  = mie_reg_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;

      if (trap_valid) begin
         mepc_d    = {trap_pc[31:2], 2'b00};
         mcause_d  = trap_cause;
         mtval_d   = trap_tval;
         st_mpie_d = st_mie_q;
         st_mie_d  = 1'b0;
      end else begin
         if (mret) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
         end else if (wr_ok && csr_addr == CSR_MSTATUS) begin
            st_mie_d  = csr_wdata[MSTATUS_MIE];
            st_mpie_d = csr_wdata[MSTATUS_MPIE];
         end
         if (wr_ok && csr_addr == CSR_MEPC)   mepc_d   = {csr_wdata[31:2], 2'b00};
         if (wr_ok && csr_addr == CSR_MCAUSE) mcause_d = csr_wdata;
         if (wr_ok && csr_addr == CSR_MTVAL)  mtval_d  = csr_wdata;
      end

      if (wr_ok && csr_addr == CSR_MIE)      mie_reg_d  = csr_wdata & MIE_WMASK;
      if (wr_ok && csr_addr == CSR_MTVEC)    mtvec_d    = {csr_wdata[31:2], 2'b00};
      if (wr_ok && csr_addr == CSR_MSCRATCH) mscratch_d = csr_wdata;
   end

   // CSR state registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_mie_q   <= 1'b0;
         st_mpie_q  <= 1'b0;
         mie_reg_q  <= 32'h0;
         mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
         mscratch_q <= 32'h0;
         mepc_q     <= 32'h0;
         mcause_q   <= 32'h0;
         mtval_q    <= 32'h0;
      end else begin
         st_mie_q   <= st_mie_d;
         st_mpie_q  <= st_mpie_d;
         mie_reg_q  <= mie_reg_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
      end
   end

   csr_counter64 u_mcycle (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (1'b1),
      .we_lo (wr_ok && csr_addr == CSR_MCYCLE),
      .we_hi (wr_ok && csr_addr == CSR_MCYCLEH),
      .wdata (csr_wdata),
      .value (mcycle_val)
   );

   csr_counter64 u_minstret (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (instr_retire && !trap_valid),
      .we_lo (wr_ok && csr_addr == CSR_MINSTRET),
      .we_hi (wr_ok && csr_addr == CSR_MINSTRETH),
      .wdata (csr_wdata),
      .value (minstret_val)
   );

   assign mtvec_out  = mtvec_q;
   assign mepc_out   = mepc_q;
   assign mie_global = st_mie_q;

endmodule

// File: tb/tb_csr_file.sv
// Randomized bench for csr_file against an architectural model of the
// machine-mode CSRs, preceded by a short directed sequence.
module tb_csr_file;

   localparam logic [31:0] HART = 32'd0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] csr_addr;
   logic [31:0] csr_rdata;
   logic        csr_we;
   logic [31:0] csr_wdata;
   logic        illegal_csr;
   logic        instr_retire;
   logic        trap_valid;
   logic [31:0] trap_pc, trap_cause, trap_tval;
   logic        mret;
   logic [31:0] mtvec_out, mepc_out;
   logic        mie_global;

   int n_cmp = 0;
   int n_bad = 0;

   // Architectural model state
   logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
   logic [63:0] m_cyc, m_ins;

   csr_file #(.HART_ID(HART), .MISA_VAL(32'h4000_0100), .MTVEC_RESET(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csr_rdata(csr_rdata),
      .csr_we(csr_we), .csr_wdata(csr_wdata), .illegal_csr(illegal_csr),
      .instr_retire(instr_retire), .trap_valid(trap_valid), .trap_pc(trap_pc),
      .trap_cause(trap_cause), .trap_tval(trap_tval), .mret(mret),
      .mtvec_out(mtvec_out), .mepc_out(mepc_out), .mie_global(mie_global)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mstatus = 32'h1800; m_mie = 0; m_mtvec = 0; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
   endtask

   // {implemented, value} for an address
   function automatic logic [32:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return {1'b1, m_mstatus};
         12'h301: return {1'b1, 32'h4000_0100};
         12'h304: return {1'b1, m_mie};
         12'h305: return {1'b1, m_mtvec};
         12'h340: return {1'b1, m_mscratch};
         12'h341: return {1'b1, m_mepc};
         12'h342: return {1'b1, m_mcause};
         12'h343: return {1'b1, m_mtval};
         12'hB00, 12'hC00: return {1'b1, m_cyc[31:0]};
         12'hB80, 12'hC80: return {1'b1, m_cyc[63:32]};
         12'hB02, 12'hC02: return {1'b1, m_ins[31:0]};
         12'hB82, 12'hC82: return {1'b1, m_ins[63:32]};
         12'hF14: return {1'b1, HART};
         default: return 33'h0;
      endcase
   endfunction

   task automatic drive(input logic [11:0] a, input logic we, input logic [31:0] wd,
                        input logic ret, input logic tr, input logic [31:0] pc,
                        input logic [31:0] cause, input logic [31:0] tval, input logic mr);
      csr_addr = a; csr_we = we; csr_wdata = wd; instr_retire = ret;
      trap_valid = tr; trap_pc = pc; trap_cause = cause; trap_tval = tval; mret = mr;
      #1;
   endtask

   task automatic idle(input logic [11:0] a);
      drive(a, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Compare combinational outputs with the model, advance the model, cross a clock edge
   task automatic step();
      logic [32:0] r;
      logic        legal;
      logic [31:0] lo;
      logic [63:0] n_cyc, n_ins;
      logic [63:0] ins_inc;
      r = m_read(csr_addr);
      check("rdata", {32'h0, csr_rdata}, {32'h0, r[31:0]});
      check("illegal", {63'h0, illegal_csr},
            {63'h0, !r[32] || (csr_we && csr_addr[11:10] == 2'b11)});
      check("mtvec_out", {32'h0, mtvec_out}, {32'h0, m_mtvec});
      check("mepc_out", {32'h0, mepc_out}, {32'h0, m_mepc});
      check("mie_global", {63'h0, mie_global}, {63'h0, m_mstatus[3]});
      if (!rst_n) begin
         model_reset();
      end else begin
         legal   = csr_we && r[32] && csr_addr[11:10] != 2'b11;
         ins_inc = (instr_retire && !trap_valid) ? 64'd1 : 64'd0;
         n_cyc   = m_cyc + 64'd1;
         n_ins   = m_ins + ins_inc;
         if (legal) begin
            case (csr_addr)
               12'hB00: n_cyc = {m_cyc[63:32], csr_wdata};
               12'hB80: begin lo = m_cyc[31:0] + 32'd1; n_cyc = {csr_wdata, lo}; end
               12'hB02: n_ins = {m_ins[63:32], csr_wdata};
               12'hB82: begin lo = m_ins[31:0] + ins_inc[31:0]; n_ins = {csr_wdata, lo}; end
               12'h304: m_mie = csr_wdata & 32'h888;
               12'h305: m_mtvec = csr_wdata & ~32'h3;
               12'h340: m_mscratch = csr_wdata;
               default: ;
            endcase
         end
         if (trap_valid) begin
            m_mepc = trap_pc & ~32'h3; m_mcause = trap_cause; m_mtval = trap_tval;
            m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
         end else begin
            if (mret) m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
            else if (legal && csr_addr == 12'h300) m_mstatus = 32'h1800 | (csr_wdata & 32'h88);
            if (legal && csr_addr == 12'h341) m_mepc = csr_wdata & ~32'h3;
            if (legal && csr_addr == 12'h342) m_mcause = csr_wdata;
            if (legal && csr_addr == 12'h343) m_mtval = csr_wdata;
         end
         m_cyc = n_cyc;
         m_ins = n_ins;
      end
      @(negedge clk);
   endtask

   logic [11:0] addrs [0:21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                                 12'hC00, 12'hC02, 12'hC80, 12'hC82, 12'hF14, 12'h7C0,
                                 12'h000, 12'h344, 12'hC01, 12'hF11};

   initial begin
      rst_n = 1'b0;
      idle(12'h0);
      repeat (2) @(negedge clk);
      model_reset();
      rst_n = 1'b1;

      // Reset values and decode
      idle(12'h300); check("mstatus_rst", {32'h0, csr_rdata}, 64'h1800);
      check("legal_rd", {63'h0, illegal_csr}, 64'h0); step();
      idle(12'h301); check("misa", {32'h0, csr_rdata}, 64'h4000_0100); step();
      idle(12'hF14); check("mhartid", {32'h0, csr_rdata}, {32'h0, HART}); step();
      idle(12'h7C0); check("unimpl_rd", {32'h0, csr_rdata}, 64'h0);
      check("unimpl_ill", {63'h0, illegal_csr}, 64'h1); step();

      // Write latency and hardwired bits
      drive(12'h340, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
      check("mscratch_old", {32'h0, csr_rdata}, 64'h0); step();
      idle(12'h340); check("mscratch_new", {32'h0, csr_rdata}, 64'hDEAD_BEEF); step();
      drive(12'h305, 1, 32'h8000_0003, 0, 0, 0, 0, 0, 0); step();
      idle(12'h305); check("mtvec_mask", {32'h0, csr_rdata}, 64'h8000_0000);
      check("mtvec_out_d", {32'h0, mtvec_out}, 64'h8000_0000); step();

      // Trap entry and mret
      drive(12'h300, 1, 32'h8, 0, 0, 0, 0, 0, 0); step();
      drive(12'h000, 0, 0, 0, 1, 32'h106, 32'hB, 32'h1234, 0); step();
      idle(12'h341); check("trap_mepc", {32'h0, csr_rdata}, 64'h104); step();
      idle(12'h342); check("trap_mcause", {32'h0, csr_rdata}, 64'hB); step();
      idle(12'h343); check("trap_mtval", {32'h0, csr_rdata}, 64'h1234); step();
      idle(12'h300); check("trap_mstatus", {32'h0, csr_rdata}, 64'h1880);
      check("trap_mie_g", {63'h0, mie_global}, 64'h0); step();
      drive(12'h000, 0, 0, 0, 0, 0, 0, 0, 1); step();
      idle(12'h300); check("mret_mstatus", {32'h0, csr_rdata}, 64'h1888);
      check("mret_mie_g", {63'h0, mie_global}, 64'h1); step();

      // mcycle carry and write-over-increment
      drive(12'hB00, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0); step();
      idle(12'hB00); check("mcycle_wr", {32'h0, csr_rdata}, 64'hFFFF_FFFF); step();
      idle(12'hB00); check("mcycle_wrap", {32'h0, csr_rdata}, 64'h0); step();
      idle(12'hB80); check("mcycleh_carry", {32'h0, csr_rdata}, 64'h1); step();
      drive(12'hB00, 1, 32'h55, 0, 0, 0, 0, 0, 0); step();
      idle(12'hB00); check("mcycle_exact", {32'h0, csr_rdata}, 64'h55); step();

      // Trap suppresses retire count and overrides a software mepc write
      drive(12'hB02, 0, 0, 1, 1, 32'h0, 32'h2, 32'h0, 0); step();
      idle(12'hB02); check("minstret_trap", {32'h0, csr_rdata}, 64'h0); step();
      drive(12'h341, 1, 32'hFFFF_FFF0, 0, 1, 32'h20B, 32'h3, 32'h0, 0); step();
      idle(12'h341); check("mepc_trap_wins", {32'h0, csr_rdata}, 64'h208); step();

      // Read-only write rejected; cycle keeps counting
      drive(12'hC00, 1, 32'h0, 0, 0, 0, 0, 0, 0);
      check("ro_ill", {63'h0, illegal_csr}, 64'h1); step();
      idle(12'hC00); step();
      idle(12'hC00); step();

      // Randomized traffic with occasional reset
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] wd;
         wd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         rst_n = ($urandom_range(0, 99) != 0);
         drive(addrs[$urandom_range(0, 21)], $urandom_range(0, 1) == 1, wd,
               $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom,
               $urandom, $urandom, $urandom_range(0, 7) == 0);
         step();
      end
      rst_n = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
